// File: rtl/ovi_pkg.sv
// ---------------------------------------------------------------------------
// ovi_pkg
// Shared types and constants for the OVI core-side issue controller:
// scoreboard ID and ring-pointer types, per-entry lifecycle state, the
// completion record stored per entry, and a pointer-distance helper.
// ---------------------------------------------------------------------------
package ovi_pkg;

    localparam int OVI_SB_DEPTH = 32;
    localparam int OVI_SB_W     = $clog2(OVI_SB_DEPTH);

    typedef logic [OVI_SB_W-1:0] ovi_sb_id_t;
    // One extra MSB so that full (distance 32) and empty (distance 0) differ.
    typedef logic [OVI_SB_W:0]   ovi_ptr_t;

    typedef enum logic [1:0] {
        ENT_FREE   = 2'd0,
        ENT_ISSUED = 2'd1,
        ENT_SENIOR = 2'd2,
        ENT_DONE   = 2'd3
    } ovi_entry_state_e;

    typedef struct packed {
        logic [4:0]  fflags;
        logic [63:0] dest_reg;
        logic        vxsat;
        logic [13:0] vstart;
        logic        illegal;
    } ovi_completion_t;

    // Number of entries from older_ptr up to (not including) newer_ptr.
    function automatic ovi_ptr_t ptr_span(input ovi_ptr_t older_ptr, input ovi_ptr_t newer_ptr);
        return newer_ptr - older_ptr;
    endfunction

endpackage

// File: rtl/ovi_core_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// ovi_core_issue_ctrl_if
// Bundles every non-clock signal of ovi_core_issue_ctrl: core request,
// commit decision, OVI issue/credit/dispatch/completion, in-order response
// and the protocol-error flag.
//   slave  : the controller's view (req_*/cmt_*/issue_credit/completed_*/
//            resp_ready in; issue_*/dispatch_*/resp_*/req_ready/proto_err out)
//   master : the environment's view (directions reversed)
// ---------------------------------------------------------------------------
interface ovi_core_issue_ctrl_if;
    import ovi_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_inst;
    logic [63:0] req_scalar_opnd;
    logic [39:0] req_vcsr;
    ovi_sb_id_t  req_sb_id;

    logic        cmt_valid;
    logic        cmt_kill;

    logic        issue_valid;
    logic [31:0] issue_inst;
    ovi_sb_id_t  issue_sb_id;
    logic [63:0] issue_scalar_opnd;
    logic [39:0] issue_vcsr;
    logic        issue_credit;

    ovi_sb_id_t  dispatch_sb_id;
    logic        dispatch_next_senior;
    logic        dispatch_kill;

    logic        completed_valid;
    ovi_sb_id_t  completed_sb_id;
    logic [4:0]  completed_fflags;
    logic [63:0] completed_dest_reg;
    logic        completed_vxsat;
    logic [13:0] completed_vstart;
    logic        completed_illegal;

    logic        resp_valid;
    logic        resp_ready;
    ovi_sb_id_t  resp_sb_id;
    logic [4:0]  resp_fflags;
    logic [63:0] resp_dest_reg;
    logic        resp_vxsat;
    logic [13:0] resp_vstart;
    logic        resp_illegal;

    logic        proto_err;

    modport slave (
        input  req_valid, req_inst, req_scalar_opnd, req_vcsr,
        input  cmt_valid, cmt_kill, issue_credit,
        input  completed_valid, completed_sb_id, completed_fflags, completed_dest_reg,
        input  completed_vxsat, completed_vstart, completed_illegal, resp_ready,
        output req_ready, req_sb_id,
        output issue_valid, issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr,
        output dispatch_sb_id, dispatch_next_senior, dispatch_kill,
        output resp_valid, resp_sb_id, resp_fflags, resp_dest_reg, resp_vxsat,
        output resp_vstart, resp_illegal, proto_err
    );

    modport master (
        output req_valid, req_inst, req_scalar_opnd, req_vcsr,
        output cmt_valid, cmt_kill, issue_credit,
        output completed_valid, completed_sb_id, completed_fflags, completed_dest_reg,
        output completed_vxsat, completed_vstart, completed_illegal, resp_ready,
        input  req_ready, req_sb_id,
        input  issue_valid, issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr,
        input  dispatch_sb_id, dispatch_next_senior, dispatch_kill,
        input  resp_valid, resp_sb_id, resp_fflags, resp_dest_reg, resp_vxsat,
        input  resp_vstart, resp_illegal, proto_err
    );

endinterface

// File: rtl/ovi_credit_counter.sv
// ---------------------------------------------------------------------------
// ovi_credit_counter
// Saturating count of VPU issue credits.
//   clk, reset   : clock, synchronous active-high reset (loads INIT_CREDITS)
//   inc_i        : one credit returned this cycle
//   dec_i        : one credit consumed this cycle
//   has_credit_o : count is non-zero
//   overflow_o   : an increment was attempted at MAX_CREDITS (count held)
// ---------------------------------------------------------------------------
module ovi_credit_counter #(
    parameter int MAX_CREDITS  = 16,
    parameter int INIT_CREDITS = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic dec_i,
    output logic has_credit_o,
    output logic overflow_o
);

    localparam int              CNT_W    = $clog2(MAX_CREDITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CREDITS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CREDITS);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        count_d    = count_q;
        overflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == CNT_MAX) begin
                overflow_o = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: clocked state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_INIT;
        end else begin
            count_q <= count_d;
        end
    end

    assign has_credit_o = (count_q != '0);

endmodule

// File: rtl/ovi_core_issue_ctrl.sv
// ---------------------------------------------------------------------------
// ovi_core_issue_ctrl
// Core-side OVI initiator. Allocates 5-bit scoreboard IDs in program order
// from a 32-entry ring (head = oldest unretired, dsp = oldest undispatched,
// tail = next to allocate), meters issue against VPU credits, turns commit
// decisions into dispatch pulses, and returns completions in program order.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ovi_core_issue_ctrl_if.slave (request, commit, issue,
//                credit, dispatch, completion, response, proto_err)
// Build option: define OVI_CORE_PROTO_CHECK_EN to enable the sticky
// proto_err detection; otherwise proto_err is tied low.
// ---------------------------------------------------------------------------
module ovi_core_issue_ctrl
    import ovi_pkg::*;
#(
    parameter int MAX_CREDITS  = 16,
    parameter int INIT_CREDITS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    ovi_core_issue_ctrl_if.slave  bus
);

    ovi_entry_state_e state_q [OVI_SB_DEPTH];
    ovi_entry_state_e state_d [OVI_SB_DEPTH];
    ovi_completion_t  comp_q  [OVI_SB_DEPTH];

    ovi_ptr_t   head_q, head_d, dsp_q, dsp_d, tail_q, tail_d;
    ovi_sb_id_t head_id, dsp_id, tail_id;
    ovi_ptr_t   kill_span;

    logic has_credit, credit_overflow;
    logic ring_full, kill_req, fire, cmt_ok, comp_ok, retire;

    assign head_id   = head_q[OVI_SB_W-1:0];
    assign dsp_id    = dsp_q[OVI_SB_W-1:0];
    assign tail_id   = tail_q[OVI_SB_W-1:0];
    assign kill_span = ptr_span(dsp_q, tail_q);

    ovi_credit_counter #(
        .MAX_CREDITS  (MAX_CREDITS),
        .INIT_CREDITS (INIT_CREDITS)
    ) u_credit (
        .clk          (clk),
        .reset        (reset),
        .inc_i        (bus.issue_credit),
        .dec_i        (fire),
        .has_credit_o (has_credit),
        .overflow_o   (credit_overflow)
    );

    assign ring_full     = (ptr_span(head_q, tail_q) == ovi_ptr_t'(OVI_SB_DEPTH));
    // A kill rewinds tail this cycle, so a new allocation must wait for it.
    assign kill_req      = bus.cmt_valid && bus.cmt_kill;
    assign bus.req_ready = has_credit && !ring_full && !kill_req;
    assign bus.req_sb_id = tail_id;
    assign fire          = bus.req_valid && bus.req_ready;

    assign cmt_ok  = bus.cmt_valid && (dsp_q != tail_q);
    assign comp_ok = bus.completed_valid && (state_q[bus.completed_sb_id] == ENT_SENIOR);
    assign bus.resp_valid = (state_q[head_id] == ENT_DONE);
    assign retire  = bus.resp_valid && bus.resp_ready;

    // Entry lifecycle and pointers. The events touch distinct entries:
    // fire hits tail (FREE), commit hits dsp (ISSUED), completion hits a
    // SENIOR entry and retire hits head (DONE).
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        dsp_d   = dsp_q;
        tail_d  = tail_q;
        if (fire) begin
            state_d[tail_id] = ENT_ISSUED;
            tail_d           = tail_q + ovi_ptr_t'(1);
        end
        if (cmt_ok && !bus.cmt_kill) begin
            state_d[dsp_id] = ENT_SENIOR;
            dsp_d           = dsp_q + ovi_ptr_t'(1);
        end
        if (cmt_ok && bus.cmt_kill) begin
            // Free every entry whose ring offset from dsp lies inside [dsp, tail).
            for (int i = 0; i < OVI_SB_DEPTH; i++) begin
                if ({1'b0, ovi_sb_id_t'(ovi_sb_id_t'(i) - dsp_id)} < kill_span) begin
                    state_d[i] = ENT_FREE;
                end
            end
            tail_d = dsp_q;
        end
        if (comp_ok) begin
            state_d[bus.completed_sb_id] = ENT_DONE;
        end
        if (retire) begin
            state_d[head_id] = ENT_FREE;
            head_d           = head_q + ovi_ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < OVI_SB_DEPTH; i++) begin
                state_q[i] <= ENT_FREE;
            end
            head_q <= '0;
            dsp_q  <= '0;
            tail_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            dsp_q   <= dsp_d;
            tail_q  <= tail_d;
        end
    end

    // NOTE: the completion payload array has no reset; its contents are only
    // observable through resp_*, which are masked to zero unless resp_valid.
    always_ff @(posedge clk) begin
        if (comp_ok) begin
            comp_q[bus.completed_sb_id] <= '{
                fflags:   bus.completed_fflags,
                dest_reg: bus.completed_dest_reg,
                vxsat:    bus.completed_vxsat,
                vstart:   bus.completed_vstart,
                illegal:  bus.completed_illegal
            };
        end
    end

    ovi_completion_t head_comp;
    assign head_comp         = bus.resp_valid ? comp_q[head_id] : '0;
    assign bus.resp_sb_id    = bus.resp_valid ? head_id : '0;
    assign bus.resp_fflags   = head_comp.fflags;
    assign bus.resp_dest_reg = head_comp.dest_reg;
    assign bus.resp_vxsat    = head_comp.vxsat;
    assign bus.resp_vstart   = head_comp.vstart;
    assign bus.resp_illegal  = head_comp.illegal;

    // Issue and dispatch pulses are registered one cycle after fire/commit.
    logic        issue_valid_q;
    logic [31:0] issue_inst_q;
    ovi_sb_id_t  issue_sb_id_q;
    logic [63:0] issue_opnd_q;
    logic [39:0] issue_vcsr_q;
    ovi_sb_id_t  dsp_sb_id_q;
    logic        dsp_senior_q, dsp_kill_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            issue_inst_q  <= '0;
            issue_sb_id_q <= '0;
            issue_opnd_q  <= '0;
            issue_vcsr_q  <= '0;
            dsp_sb_id_q   <= '0;
            dsp_senior_q  <= 1'b0;
            dsp_kill_q    <= 1'b0;
        end else begin
            issue_valid_q <= fire;
            if (fire) begin
                issue_inst_q  <= bus.req_inst;
                issue_sb_id_q <= tail_id;
                issue_opnd_q  <= bus.req_scalar_opnd;
                issue_vcsr_q  <= bus.req_vcsr;
            end
            dsp_senior_q <= cmt_ok && !bus.cmt_kill;
            dsp_kill_q   <= cmt_ok && bus.cmt_kill;
            if (cmt_ok) begin
                dsp_sb_id_q <= dsp_id;
            end
        end
    end

    assign bus.issue_valid          = issue_valid_q;
    assign bus.issue_inst           = issue_inst_q;
    assign bus.issue_sb_id          = issue_sb_id_q;
    assign bus.issue_scalar_opnd    = issue_opnd_q;
    assign bus.issue_vcsr           = issue_vcsr_q;
    assign bus.dispatch_sb_id       = dsp_sb_id_q;
    assign bus.dispatch_next_senior = dsp_senior_q;
    assign bus.dispatch_kill        = dsp_kill_q;

`ifdef OVI_CORE_PROTO_CHECK_EN
    logic proto_err_q, proto_err_d;
    logic cmt_err, comp_err;

    assign cmt_err     = bus.cmt_valid && (dsp_q == tail_q);
    assign comp_err    = bus.completed_valid && !comp_ok;
    assign proto_err_d = proto_err_q || credit_overflow || cmt_err || comp_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.proto_err = proto_err_q;
`else
    logic unused_credit_overflow;
    assign unused_credit_overflow = credit_overflow;
    assign bus.proto_err          = 1'b0;
`endif

endmodule

// File: doc/ovi_core_issue_ctrl.md
# ovi_core_issue_ctrl

Core-side initiator of the Open Vector Interface (OVI): the scalar-core end that drives `issue_*` and `dispatch_*` toward the VPU and consumes `issue_credit` and `completed_*`. It accepts vector instructions from the core pipeline and allocates 5-bit scoreboard IDs in program order. It meters issue against VPU credits, forwards commit/kill decisions as dispatch messages, and returns completions to the core in program order.

## Interface
- `MAX_CREDITS`, 16: largest credit count the VPU may grant; sizes the credit counter.
- `INIT_CREDITS`, 0: credit count loaded at reset.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: core offers a vector instruction.
- `req_ready` out 1: instruction accepted when both `req_valid` and `req_ready` are high (fire).
- `req_inst` in 32; `req_scalar_opnd` in 64; `req_vcsr` in 40: instruction payload.
- `req_sb_id` out 5: ID assigned to the instruction on fire.
- `cmt_valid` in 1; `cmt_kill` in 1: commit decision for the oldest undispatched entry (0 = senior, 1 = kill).
- `issue_valid` out 1; `issue_inst` out 32; `issue_sb_id` out 5; `issue_scalar_opnd` out 64; `issue_vcsr` out 40: OVI issue.
- `issue_credit` in 1: one-cycle pulse returning one credit.
- `dispatch_sb_id` out 5; `dispatch_next_senior` out 1; `dispatch_kill` out 1: OVI dispatch.
- `completed_valid` in 1; `completed_sb_id` in 5; `completed_fflags` in 5; `completed_dest_reg` in 64; `completed_vxsat` in 1; `completed_vstart` in 14; `completed_illegal` in 1: OVI completion.
- `resp_valid` out 1; `resp_ready` in 1; `resp_sb_id` out 5; `resp_fflags` out 5; `resp_dest_reg` out 64; `resp_vxsat` out 1; `resp_vstart` out 14; `resp_illegal` out 1: in-order completion to the core.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- 32-entry ring indexed by sb_id, with three 6-bit pointers:
  - `head`: oldest unretired entry.
  - `dsp`: oldest undispatched entry.
  - `tail`: next ID to allocate.
- Entry states: FREE → ISSUED → SENIOR → DONE → FREE.
- Credit counter:
  - +1 on `issue_credit`, −1 on fire; both in the same cycle leaves it unchanged.
  - Reset value `INIT_CREDITS`.
  - An increment beyond `MAX_CREDITS` saturates and sets `proto_err`.
- `req_ready` = credits ≠ 0 && ring not full (`tail − head` ≠ 32) && !(`cmt_valid && cmt_kill`). Combinational.
- On fire:
  - `req_sb_id` = `tail[4:0]`.
  - The entry goes ISSUED, the payload is registered onto `issue_*`, and `tail` increments.
- Commit with `cmt_valid`, `dsp` ≠ `tail`:
  - Senior: the entry goes SENIOR, `dsp` increments, and a dispatch is emitted with `next_senior=1`.
  - Kill: `dispatch_kill=1` is emitted for sb_id `dsp`, all entries from `dsp` to `tail−1` go FREE, and `tail` := `dsp`.
- Commit with `dsp` == `tail` is ignored and sets `proto_err`.
- `dispatch_next_senior` and `dispatch_kill` are never high together.
- Completion:
  - A completion whose entry is SENIOR stores its fields and moves the entry to DONE.
  - A completion for any other state sets `proto_err` and is dropped.
  - A completion for an ISSUED (not yet senior) entry is also an error.
- Retirement:
  - `resp_valid` is high iff the head entry is DONE; `resp_*` come from that entry.
  - On `resp_valid && resp_ready` the entry goes FREE and `head` increments.
- Wrap-around: pointers are 6 bits; full/empty are determined by the MSB.

## Timing
- Issue: fire in cycle N gives `issue_valid` as a one-cycle pulse in N+1 with the registered payload. At most one issue per cycle.
- Dispatch: commit in cycle N gives the dispatch pulse in N+1.
- Completion in cycle N gives `resp_valid` in N+1 at the earliest, if that entry is at the head.
- Simultaneous events in the same cycle:
  - Commit kill and `req_valid`: the request is held (`req_ready`=0).
  - Completion and retire of different entries proceed in parallel.
  - Credit return and fire: see credit rule.
- Reset values:
  - Credits = `INIT_CREDITS`; all pointers 0; all entries FREE.
  - All `issue_*`, `dispatch_*`, and `resp_*` outputs 0.
  - `proto_err` 0.
- Reset mid-operation discards all entries with no dispatch or kill emitted. Outputs are 0 in the cycle after reset is sampled.

## Configuration
- `OVI_CORE_PROTO_CHECK_EN` defined: `proto_err` detection as specified above.
- Not defined: no checks; `proto_err` is tied to 0.
  - Illegal completions still never change entry state.
  - The credit counter still saturates.

## Structure
- Shared package `ovi_pkg`:
  - `ovi_sb_id_t` (5 bits).
  - `ovi_entry_state_e`.
  - `ovi_completion_t`: fflags, dest_reg, vxsat, vstart, illegal.
  - Constant `OVI_SB_DEPTH = 32`.
- One sub-module: `ovi_credit_counter`, holding the saturating credit count, its overflow flag, and the `has_credit` output.

## Test plan
- `INIT_CREDITS=0`, `req_valid` held: `req_ready`=0. After 2 `issue_credit` pulses, exactly 2 issues occur with sb_id 0 and 1, then `req_ready`=0.
- Issue 3, commit senior ×3: dispatch pulses with sb_id 0, 1, 2. Complete in order 2, 0, 1: `resp` order is 0, 1, 2; sb 0 is returned one cycle after its completion.
- Issue 4 (ids 0–3), commit senior id 0, then kill: `dispatch_kill` with sb_id 1; next fire gets `req_sb_id`=1.
- Fill 32 entries with ample credits: `req_ready`=0 at count 32. Retire one: the next allocation gets id 0 via wrap.
- With `OVI_CORE_PROTO_CHECK_EN`, a completion for an ISSUED entry sets `proto_err`=1 sticky and leaves the entry unchanged. Without the macro, `proto_err` stays 0.
- Reset asserted with 5 entries in flight: next cycle all outputs 0, credits = `INIT_CREDITS`, next allocation gets id 0.
